// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH independent PWM channels with
// standard, breathing and center-aligned modes.
module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int STEP_W = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2*NUM_CH-1:0]      mode_i,
  input  logic [CNT_W*NUM_CH-1:0]  period_i,
  input  logic [CNT_W*NUM_CH-1:0]  thr1_i,
  input  logic [CNT_W*NUM_CH-1:0]  thr2_i,
  input  logic [STEP_W*NUM_CH-1:0] step_i,
  input  logic                     sync_i,
  output logic [NUM_CH-1:0]        pwm_o,
  output logic [NUM_CH-1:0]        period_end_o
);

  typedef enum logic [1:0] {
    M_OFF = 2'd0,
    M_STD = 2'd1,
    M_BRE = 2'd2,
    M_CTR = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mode_e              m_in;
    logic [CNT_W-1:0]   p_in, t1_in, t2_in;
    logic [STEP_W-1:0]  s_in;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   duty_q, duty_d;
    logic [CNT_W-1:0]   p_s_q, p_s_d;
    logic [CNT_W-1:0]   t1_s_q, t1_s_d;
    logic [CNT_W-1:0]   t2_s_q, t2_s_d;
    logic [STEP_W-1:0]  s_s_q, s_s_d;
    logic               dir_q, dir_d;
    logic               pwm_q, pwm_d;
    logic               pe_q, pe_d;
    logic               wrap, reload;
    logic [CNT_W:0]     s_ext, up_sum, lo_sum;

    assign m_in   = mode_e'(mode_i[2*c+:2]);
    assign p_in   = period_i[CNT_W*c+:CNT_W];
    assign t1_in  = thr1_i[CNT_W*c+:CNT_W];
    assign t2_in  = thr2_i[CNT_W*c+:CNT_W];
    assign s_in   = step_i[STEP_W*c+:STEP_W];

    // one extra bit so ramp sums never wrap
    assign s_ext  = (CNT_W+1)'(s_in);
    assign up_sum = {1'b0, duty_q} + s_ext;
    assign lo_sum = {1'b0, t1_in} + s_ext;

    // next state: mode entry > sync > short period > count
    always_comb begin
      mode_d = mode_q;
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      duty_d = duty_q;
      p_s_d  = p_s_q;
      t1_s_d = t1_s_q;
      t2_s_d = t2_s_q;
      s_s_d  = s_s_q;
      pwm_d  = 1'b0;
      pe_d   = 1'b0;
      wrap   = 1'b0;
      reload = 1'b0;
      if (m_in != mode_q) begin
        mode_d = m_in;
        cnt_d  = '0;
        dir_d  = 1'b0;
        duty_d = t1_in;
        reload = 1'b1;
      end else if (mode_q == M_OFF) begin
        cnt_d = '0;
      end else if (sync_i) begin
        cnt_d = '0;
        dir_d = 1'b0;
      end else if (p_s_q < TWO) begin
        cnt_d  = '0;
        reload = 1'b1;
      end else begin
        unique case (1'b1)
          (mode_q == M_CTR): begin
            pwm_d = (cnt_q < t1_s_q);
            if (!dir_q) begin
              if (cnt_q == p_s_q - ONE) begin
                if (cnt_q == ONE) begin
                  wrap = 1'b1;
                end else begin
                  dir_d = 1'b1;
                  cnt_d = cnt_q - ONE;
                end
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end else if (cnt_q == ONE) begin
              wrap  = 1'b1;
              dir_d = 1'b0;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
          default: begin
            pwm_d = (cnt_q < ((mode_q == M_BRE) ?
                              duty_q : t1_s_q));
            if (cnt_q == p_s_q - ONE) begin
              wrap = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
        endcase
      end
      if (wrap) begin
        cnt_d  = '0;
        pe_d   = 1'b1;
        reload = 1'b1;
      end
      if (reload) begin
        p_s_d  = p_in;
        t1_s_d = t1_in;
        t2_s_d = t2_in;
        s_s_d  = s_in;
      end
      // ramp uses the freshly reloaded bounds
      if (wrap && mode_q == M_BRE) begin
        if (t1_in >= t2_in || s_in == '0) begin
          duty_d = t1_in;
        end else if (!dir_q) begin
          if (up_sum >= {1'b0, t2_in}) begin
            duty_d = t2_in;
            dir_d  = 1'b1;
          end else begin
            duty_d = up_sum[CNT_W-1:0];
          end
        end else if ({1'b0, duty_q} <= lo_sum) begin
          duty_d = t1_in;
          dir_d  = 1'b0;
        end else begin
          duty_d = duty_q - s_ext[CNT_W-1:0];
        end
      end
    end

    // channel state and registered outputs
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mode_q <= M_OFF;
        cnt_q  <= '0;
        dir_q  <= 1'b0;
        duty_q <= '0;
        p_s_q  <= '0;
        t1_s_q <= '0;
        t2_s_q <= '0;
        s_s_q  <= '0;
        pwm_q  <= 1'b0;
        pe_q   <= 1'b0;
      end else begin
        mode_q <= mode_d;
        cnt_q  <= cnt_d;
        dir_q  <= dir_d;
        duty_q <= duty_d;
        p_s_q  <= p_s_d;
        t1_s_q <= t1_s_d;
        t2_s_q <= t2_s_d;
        s_s_q  <= s_s_d;
        pwm_q  <= pwm_d;
        pe_q   <= pe_d;
      end
    end

    assign pwm_o[c]        = pwm_q;
    assign period_end_o[c] = pe_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed stimulus, period-position model
// checked every cycle, plus hand-computed window counts.
module tb_pwm_multi;
  localparam int NC = 4;
  localparam int CW = 32;
  localparam int SW = 12;

  logic             clk;
  logic             rst;
  logic [2*NC-1:0]  mode;
  logic [CW*NC-1:0] period, thr1, thr2;
  logic [SW*NC-1:0] step;
  logic             sync;
  logic [NC-1:0]    pwm_o, pe_o;

  pwm_multi #(.NUM_CH(NC), .CNT_W(CW), .STEP_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode),
    .period_i(period), .thr1_i(thr1), .thr2_i(thr2),
    .step_i(step), .sync_i(sync),
    .pwm_o(pwm_o), .period_end_o(pe_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: position t within a period of length len
  logic [1:0]  m_mode [NC];
  logic [63:0] m_p [NC], m_t1 [NC], m_t2 [NC], m_s [NC];
  logic [63:0] m_duty [NC], m_t [NC];
  logic        m_down [NC];
  logic        e_pwm [NC], e_pe [NC];
  logic [1:0]  mi;
  logic [63:0] pi, t1i, t2i, si, len, pos, thr;

  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      mi  = mode[2*c+:2];
      pi  = 64'(period[CW*c+:CW]);
      t1i = 64'(thr1[CW*c+:CW]);
      t2i = 64'(thr2[CW*c+:CW]);
      si  = 64'(step[SW*c+:SW]);
      e_pwm[c] = 1'b0;
      e_pe[c]  = 1'b0;
      if (rst) begin
        m_mode[c] = 2'd0; m_p[c] = 0; m_t1[c] = 0;
        m_t2[c] = 0; m_s[c] = 0; m_duty[c] = 0;
        m_t[c] = 0; m_down[c] = 1'b0;
      end else if (mi != m_mode[c]) begin
        m_mode[c] = mi; m_t[c] = 0; m_down[c] = 1'b0;
        m_p[c] = pi; m_t1[c] = t1i; m_t2[c] = t2i;
        m_s[c] = si; m_duty[c] = t1i;
      end else if (m_mode[c] == 2'd0) begin
        m_t[c] = 0;
      end else if (sync) begin
        m_t[c] = 0; m_down[c] = 1'b0;
      end else if (m_p[c] < 2) begin
        m_p[c] = pi; m_t1[c] = t1i; m_t2[c] = t2i;
        m_s[c] = si;
      end else begin
        len = (m_mode[c] == 2'd3) ? 2*(m_p[c]-1) : m_p[c];
        pos = (m_mode[c] == 2'd3 && m_t[c] >= m_p[c]) ?
              len - m_t[c] : m_t[c];
        thr = (m_mode[c] == 2'd2) ? m_duty[c] : m_t1[c];
        e_pwm[c] = (pos < thr);
        m_t[c] = m_t[c] + 1;
        if (m_t[c] == len) begin
          m_t[c] = 0; e_pe[c] = 1'b1;
          m_p[c] = pi; m_t1[c] = t1i; m_t2[c] = t2i;
          m_s[c] = si;
          if (m_mode[c] == 2'd2) begin
            if (m_t1[c] >= m_t2[c] || m_s[c] == 0)
              m_duty[c] = m_t1[c];
            else if (!m_down[c]) begin
              if (m_duty[c] + m_s[c] >= m_t2[c]) begin
                m_duty[c] = m_t2[c]; m_down[c] = 1'b1;
              end else m_duty[c] = m_duty[c] + m_s[c];
            end else if (m_duty[c] <= m_t1[c] + m_s[c]) begin
              m_duty[c] = m_t1[c]; m_down[c] = 1'b0;
            end else m_duty[c] = m_duty[c] - m_s[c];
          end
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int hi_tot [NC];
  int pe_tot [NC];
  int hi_snap [NC];
  int pe_snap [NC];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("pwm%0d@%0t", c, $time),
          64'(pwm_o[c]), 64'(e_pwm[c]));
      chk($sformatf("pe%0d@%0t", c, $time),
          64'(pe_o[c]), 64'(e_pe[c]));
      hi_tot[c] += int'(pwm_o[c]);
      pe_tot[c] += int'(pe_o[c]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    for (int c = 0; c < NC; c++) begin
      hi_snap[c] = hi_tot[c];
      pe_snap[c] = pe_tot[c];
    end
  endtask

  task automatic win(input string nm, input int c,
                     input int hi, input int pe);
    chk({nm, "_hi"}, 64'(hi_tot[c] - hi_snap[c]), 64'(hi));
    chk({nm, "_pe"}, 64'(pe_tot[c] - pe_snap[c]), 64'(pe));
  endtask

  task automatic set_ch(input int c, input logic [1:0] m,
                        input logic [31:0] p, t1, t2,
                        input logic [11:0] s);
    mode[2*c+:2]     = m;
    period[CW*c+:CW] = p;
    thr1[CW*c+:CW]   = t1;
    thr2[CW*c+:CW]   = t2;
    step[SW*c+:SW]   = s;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      hi_tot[c] = 0; pe_tot[c] = 0;
    end
    rst = 1'b1; sync = 1'b0; mode = '0;
    period = '0; thr1 = '0; thr2 = '0; step = '0;
    run(3);
    chk("rst_pwm", 64'(pwm_o), 64'h0);
    chk("rst_pe", 64'(pe_o), 64'h0);

    // std, breathe, center, degenerate std
    rst = 1'b0;
    set_ch(0, 2'd1, 10, 3, 0, 0);
    set_ch(1, 2'd2, 8, 0, 8, 2);
    set_ch(2, 2'd3, 5, 2, 0, 0);
    set_ch(3, 2'd1, 1, 1, 0, 0);
    tick();
    chk("entry_pwm", 64'(pwm_o), 64'h0);
    chk("entry_pe", 64'(pe_o), 64'h0);
    snap();
    tick();
    chk("first_pwm", 64'(pwm_o), 64'b0101);
    run(39);
    win("std_a", 0, 12, 4);
    win("bre_a", 1, 20, 5);
    win("ctr_a", 2, 15, 5);
    win("deg_a", 3, 0, 0);
    snap();
    run(40);
    win("std_b", 0, 12, 4);
    win("bre_b", 1, 14, 5);
    win("ctr_b", 2, 15, 5);

    // duty change mid-period waits for the wrap
    snap();
    run(5);
    thr1[CW*0+:CW] = 7;
    run(5);
    win("thr_old", 0, 3, 1);
    snap();
    run(10);
    win("thr_new", 0, 7, 1);

    // sync lands where ch0 would wrap
    set_ch(1, 2'd1, 6, 1, 0, 0);
    set_ch(2, 2'd1, 9, 4, 0, 0);
    set_ch(3, 2'd1, 7, 2, 0, 0);
    run(9);
    sync = 1'b1;
    tick();
    chk("sync_pwm", 64'(pwm_o), 64'h0);
    chk("sync_pe", 64'(pe_o), 64'h0);
    sync = 1'b0;
    snap();
    tick();
    chk("sync_next", 64'(pwm_o), 64'b1111);
    run(9);
    win("sync_c0", 0, 7, 1);
    win("sync_c3", 3, 4, 1);

    // breathe near the top of the counter range
    set_ch(1, 2'd2, 8, 32'hFFFF_EC78, 32'hFFFF_FFFF,
           12'hFFF);
    tick();
    snap();
    run(32);
    win("bre_top", 1, 32, 4);

    // reset mid-period
    rst = 1'b1;
    tick();
    chk("midrst_pwm", 64'(pwm_o), 64'h0);
    chk("midrst_pe", 64'(pe_o), 64'h0);
    rst = 1'b0;

    // off and short periods
    set_ch(0, 2'd0, 10, 3, 0, 0);
    set_ch(2, 2'd2, 1, 1, 5, 1);
    set_ch(3, 2'd3, 0, 1, 0, 0);
    tick();
    snap();
    run(20);
    win("off_c0", 0, 0, 0);
    win("p1_c2", 2, 0, 0);
    win("p0_c3", 3, 0, 0);
    period[CW*3+:CW] = 4;
    run(2);
    chk("p_valid", 64'(pwm_o[3]), 64'h1);
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
